ex_mem_reg: RTL and testbench

EX/MEM pipeline register of the 8-bit RISC-V pipeline. It captures the EX stage's ALU result, store data, zero flag, destination register, branch target and control bits, then drives the MEM stage inputs for one cycle per instruction. It supports stall (hold), flush (bubble insertion) and automatic wrong-path squash after a taken branch. Control outputs are gated so that a bubble never writes memory, writes the register file or redirects the PC.

---
 rtl/ex_mem_reg.sv | 178 +++++++++++++++++
 tb/tb_ex_mem_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg : EX/MEM pipeline register of the 8-bit RISC-V pipeline.
//
// Captures the EX-stage ALU result, store data, zero flag, destination
// register, branch target and control bits, and presents them to the MEM
// stage one cycle later. Supports stall (hold), flush (bubble) and an
// automatic wrong-path squash when a taken branch sits in MEM (pc_src=1).
// Control outputs are ANDed with valid so that a bubble can never write
// memory, write the register file or redirect the PC.
//
// Per-edge priority: reset > flush > pc_src squash > stall > load.
//
// Optional feature macro: EXMEM_PERF_CNT_EN
//   When defined, three 16-bit saturating performance counters and their
//   ports (retired_cnt, bubble_cnt, taken_cnt) are present.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous active-low reset
//   stall / flush      hazard-unit hold / bubble request
//   pc_src             taken branch currently in MEM (squash EX instruction)
//   valid_in           EX stage holds a real instruction
//   *_in               EX control bits and data fields
//   valid_out          MEM stage holds a real instruction
//   *_out              gated control bits and stored data fields
//   retired_cnt, bubble_cnt, taken_cnt   performance counters (macro only)
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int ADDRESS_LINE   = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      pc_src,
    input  logic                      valid_in,
    input  logic                      branch_in,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      mem_to_reg_in,
    input  logic                      reg_write_in,
    input  logic                      zero_in,
    input  logic [7:0]                alu_result_in,
    input  logic [7:0]                write_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic [ADDRESS_LINE-1:0]   branch_target_in,
    output logic                      valid_out,
    output logic                      branch_out,
    output logic                      mem_read_out,
    output logic                      mem_write_out,
    output logic                      mem_to_reg_out,
    output logic                      reg_write_out,
    output logic                      zero_out,
    output logic [7:0]                alu_result_out,
    output logic [7:0]                write_data_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic [ADDRESS_LINE-1:0]   branch_target_out
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [15:0]               retired_cnt,
    output logic [15:0]               bubble_cnt,
    output logic [15:0]               taken_cnt
`endif
);

    logic                      valid_r;
    logic                      branch_r;
    logic                      mem_read_r;
    logic                      mem_write_r;
    logic                      mem_to_reg_r;
    logic                      reg_write_r;
    logic                      zero_r;
    logic [7:0]                alu_result_r;
    logic [7:0]                write_data_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic [ADDRESS_LINE-1:0]   branch_target_r;

    // A squash (pc_src) overrides stall: the EX instruction is wrong-path.
    logic bubble_s;
    assign bubble_s = flush | pc_src;

    // Pipeline register: reset, bubble insertion, hold or load.
    always_ff @(posedge clock) begin
        if (!reset || bubble_s) begin
            valid_r         <= 1'b0;
            branch_r        <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            reg_write_r     <= 1'b0;
            zero_r          <= 1'b0;
            alu_result_r    <= 8'h00;
            write_data_r    <= 8'h00;
            rd_r            <= '0;
            branch_target_r <= '0;
        end else if (stall) begin
            valid_r         <= valid_r;
            branch_r        <= branch_r;
            mem_read_r      <= mem_read_r;
            mem_write_r     <= mem_write_r;
            mem_to_reg_r    <= mem_to_reg_r;
            reg_write_r     <= reg_write_r;
            zero_r          <= zero_r;
            alu_result_r    <= alu_result_r;
            write_data_r    <= write_data_r;
            rd_r            <= rd_r;
            branch_target_r <= branch_target_r;
        end else begin
            valid_r         <= valid_in;
            branch_r        <= branch_in;
            mem_read_r      <= mem_read_in;
            mem_write_r     <= mem_write_in;
            mem_to_reg_r    <= mem_to_reg_in;
            reg_write_r     <= reg_write_in;
            zero_r          <= zero_in;
            alu_result_r    <= alu_result_in;
            write_data_r    <= write_data_in;
            rd_r            <= rd_in;
            branch_target_r <= branch_target_in;
        end
    end

    // Controls are gated by valid so a bubble carrying stale control bits
    // (a load with valid_in=0) is harmless. Only register outputs feed these.
    assign valid_out         = valid_r;
    assign branch_out        = branch_r     & valid_r;
    assign mem_read_out      = mem_read_r   & valid_r;
    assign mem_write_out     = mem_write_r  & valid_r;
    assign mem_to_reg_out    = mem_to_reg_r & valid_r;
    assign reg_write_out     = reg_write_r  & valid_r;
    assign zero_out          = zero_r;
    assign alu_result_out    = alu_result_r;
    assign write_data_out    = write_data_r;
    assign rd_out            = rd_r;
    assign branch_target_out = branch_target_r;

`ifdef EXMEM_PERF_CNT_EN
    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 16'd1;
        end
    endfunction

    logic [15:0] retired_cnt_r;
    logic [15:0] bubble_cnt_r;
    logic [15:0] taken_cnt_r;
    logic        retire_ev_s;
    logic        bubble_ev_s;
    logic        taken_ev_s;

    // A bubble enters on flush/squash or on a plain load of an empty slot.
    assign retire_ev_s = valid_r & ~stall;
    assign bubble_ev_s = bubble_s | (~stall & ~valid_in);
    assign taken_ev_s  = pc_src & valid_r;

    // Performance counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            retired_cnt_r <= 16'h0000;
            bubble_cnt_r  <= 16'h0000;
            taken_cnt_r   <= 16'h0000;
        end else begin
            retired_cnt_r <= retire_ev_s ? sat_inc(retired_cnt_r) : retired_cnt_r;
            bubble_cnt_r  <= bubble_ev_s ? sat_inc(bubble_cnt_r)  : bubble_cnt_r;
            taken_cnt_r   <= taken_ev_s  ? sat_inc(taken_cnt_r)   : taken_cnt_r;
        end
    end

    assign retired_cnt = retired_cnt_r;
    assign bubble_cnt  = bubble_cnt_r;
    assign taken_cnt   = taken_cnt_r;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// Testbench for ex_mem_reg: directed vectors, a transaction-level reference
// model updated on each rising edge, a compare process on each falling edge,
// and hand-computed literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;

    logic       clock;
    logic       reset;
    logic       stall, flush, pc_src, valid_in;
    logic       branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, zero_in;
    logic [7:0] alu_result_in, write_data_in, branch_target_in;
    logic [4:0] rd_in;
    logic       valid_out, branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, zero_out;
    logic [7:0] alu_result_out, write_data_out, branch_target_out;
    logic [4:0] rd_out;
`ifdef EXMEM_PERF_CNT_EN
    logic [15:0] retired_cnt, bubble_cnt, taken_cnt;
`endif

    ex_mem_reg #(.ADDRESS_LINE(8), .REG_ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
        .valid_in(valid_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
        .write_data_in(write_data_in), .rd_in(rd_in), .branch_target_in(branch_target_in),
        .valid_out(valid_out), .branch_out(branch_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .zero_out(zero_out), .alu_result_out(alu_result_out),
        .write_data_out(write_data_out), .rd_out(rd_out), .branch_target_out(branch_target_out)
`ifdef EXMEM_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt), .taken_cnt(taken_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the instruction sitting in MEM -----
    typedef struct packed {
        logic       v, br, mr, mw, mtr, rw, z;
        logic [7:0] alu, wd, bt;
        logic [4:0] rd;
    } slot_t;

    slot_t       m_slot;
    int          m_ret, m_bub, m_tak;
    bit          m_ok = 1'b0;

    function automatic int sat(input int x);
        return (x >= 65535) ? 65535 : x + 1;
    endfunction

    always @(posedge clock) begin
        if (reset === 1'b0) begin
            m_slot = '0;
            m_ret = 0; m_bub = 0; m_tak = 0;
            m_ok  = 1'b1;
        end else if (m_ok) begin
            // events are judged against what MEM held before this edge
            if (m_slot.v && !stall)              m_ret = sat(m_ret);
            if (pc_src && m_slot.v)              m_tak = sat(m_tak);
            if (flush || pc_src || (!stall && !valid_in)) m_bub = sat(m_bub);
            if (flush || pc_src)     m_slot = '0;
            else if (!stall)         m_slot = '{v: valid_in, br: branch_in, mr: mem_read_in,
                                                mw: mem_write_in, mtr: mem_to_reg_in,
                                                rw: reg_write_in, z: zero_in, alu: alu_result_in,
                                                wd: write_data_in, bt: branch_target_in, rd: rd_in};
        end
    end

    // Compare every cycle once the model has a defined state.
    always @(negedge clock) begin
        if (m_ok) begin
            chk("valid",      {31'd0, valid_out},      {31'd0, m_slot.v});
            chk("branch",     {31'd0, branch_out},     {31'd0, m_slot.br  & m_slot.v});
            chk("mem_read",   {31'd0, mem_read_out},   {31'd0, m_slot.mr  & m_slot.v});
            chk("mem_write",  {31'd0, mem_write_out},  {31'd0, m_slot.mw  & m_slot.v});
            chk("mem_to_reg", {31'd0, mem_to_reg_out}, {31'd0, m_slot.mtr & m_slot.v});
            chk("reg_write",  {31'd0, reg_write_out},  {31'd0, m_slot.rw  & m_slot.v});
            chk("zero",       {31'd0, zero_out},       {31'd0, m_slot.z});
            chk("alu_result", {24'd0, alu_result_out}, {24'd0, m_slot.alu});
            chk("write_data", {24'd0, write_data_out}, {24'd0, m_slot.wd});
            chk("rd",         {27'd0, rd_out},         {27'd0, m_slot.rd});
            chk("br_target",  {24'd0, branch_target_out}, {24'd0, m_slot.bt});
`ifdef EXMEM_PERF_CNT_EN
            chk("retired_cnt", {16'd0, retired_cnt}, m_ret);
            chk("bubble_cnt",  {16'd0, bubble_cnt},  m_bub);
            chk("taken_cnt",   {16'd0, taken_cnt},   m_tak);
`endif
        end
    end

    // ---------------- stimulus -------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; pc_src = 1'b0; valid_in = 1'b0;
        branch_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        mem_to_reg_in = 1'b0; reg_write_in = 1'b0; zero_in = 1'b0;
        alu_result_in = 8'h00; write_data_in = 8'h00; branch_target_in = 8'h00; rd_in = 5'd0;
    endtask

    logic [7:0] tab_alu [4] = '{8'h01, 8'hFE, 8'h80, 8'h5A};
    logic [4:0] tab_rd  [4] = '{5'd31, 5'd0, 5'd17, 5'd9};

    initial begin
        // reset held low with every input at 1
        reset = 1'b0;
        stall = 1'b1; flush = 1'b1; pc_src = 1'b1; valid_in = 1'b1;
        branch_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1;
        mem_to_reg_in = 1'b1; reg_write_in = 1'b1; zero_in = 1'b1;
        alu_result_in = 8'hFF; write_data_in = 8'hFF; branch_target_in = 8'hFF; rd_in = 5'h1F;
        tick(); tick();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_alu",   {24'd0, alu_result_out}, 32'd0);
        chk("rst_rw",    {31'd0, reg_write_out}, 32'd0);
        chk("rst_bt",    {24'd0, branch_target_out}, 32'd0);

        // first edge after release is a normal load
        reset = 1'b1; idle_inputs();
        valid_in = 1'b1; alu_result_in = 8'h3C;
        tick();
        chk("load_alu",   {24'd0, alu_result_out}, 32'h3C);
        chk("load_valid", {31'd0, valid_out}, 32'd1);

        // empty slot with stale control bits: controls gated, data kept
        valid_in = 1'b0; mem_write_in = 1'b1; reg_write_in = 1'b1; alu_result_in = 8'h11;
        tick();
        chk("gate_mw",  {31'd0, mem_write_out}, 32'd0);
        chk("gate_rw",  {31'd0, reg_write_out}, 32'd0);
        chk("gate_alu", {24'd0, alu_result_out}, 32'h11);

        // four back-to-back instructions
        for (int i = 1; i <= 4; i++) begin
            valid_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
            rd_in = 5'(i); alu_result_in = 8'(i * 16);
            tick();
            chk("flow_rd", {27'd0, rd_out}, i);
        end
`ifdef EXMEM_PERF_CNT_EN
        chk("flow_retired", {16'd0, retired_cnt}, 32'd4);
`endif

        // store then stall for 3 cycles while EX changes
        write_data_in = 8'hA5; mem_write_in = 1'b1; reg_write_in = 1'b0;
        tick();
        stall = 1'b1; write_data_in = 8'h5A; mem_write_in = 1'b0; valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wd", {24'd0, write_data_out}, 32'hA5);
            chk("stall_mw", {31'd0, mem_write_out}, 32'd1);
`ifdef EXMEM_PERF_CNT_EN
            chk("stall_retired", {16'd0, retired_cnt}, 32'd5);
`endif
        end

        // flush beats stall
        flush = 1'b1; reg_write_in = 1'b1; valid_in = 1'b1; alu_result_in = 8'h77;
        tick();
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_rw",    {31'd0, reg_write_out}, 32'd0);
        chk("flush_alu",   {24'd0, alu_result_out}, 32'd0);
`ifdef EXMEM_PERF_CNT_EN
        chk("flush_bubble", {16'd0, bubble_cnt}, 32'd2);
`endif

        // branch into MEM, then squash while stalled
        idle_inputs();
        valid_in = 1'b1; branch_in = 1'b1; branch_target_in = 8'h9A;
        tick();
        chk("br_out", {31'd0, branch_out}, 32'd1);
        chk("br_bt",  {24'd0, branch_target_out}, 32'h9A);
        pc_src = 1'b1; stall = 1'b1; mem_write_in = 1'b1; branch_in = 1'b0;
        tick();
        chk("sq_mw",    {31'd0, mem_write_out}, 32'd0);
        chk("sq_valid", {31'd0, valid_out}, 32'd0);
`ifdef EXMEM_PERF_CNT_EN
        chk("sq_taken",  {16'd0, taken_cnt}, 32'd1);
        chk("sq_bubble", {16'd0, bubble_cnt}, 32'd3);
`endif
        stall = 1'b0;
        tick();
`ifdef EXMEM_PERF_CNT_EN
        chk("sq_taken_empty", {16'd0, taken_cnt}, 32'd1);
`endif

        // assorted field patterns
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; zero_in = i[0]; mem_read_in = i[1]; mem_to_reg_in = ~i[0];
            alu_result_in = tab_alu[i]; write_data_in = ~tab_alu[i];
            rd_in = tab_rd[i]; branch_target_in = tab_alu[i] ^ 8'h33;
            tick();
        end
        chk("pat_zero", {31'd0, zero_out}, 32'd1);
        chk("pat_rd",   {27'd0, rd_out}, 32'd9);

        // reset mid-stream, then a normal load
        reset = 1'b0;
        tick();
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_alu",   {24'd0, alu_result_out}, 32'd0);
`ifdef EXMEM_PERF_CNT_EN
        chk("mid_rst_ret",   {16'd0, retired_cnt}, 32'd0);
`endif
        reset = 1'b1; alu_result_in = 8'hC3;
        tick();
        chk("rel_alu", {24'd0, alu_result_out}, 32'hC3);

`ifdef EXMEM_PERF_CNT_EN
        // saturation of the retirement counter
        idle_inputs(); valid_in = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat_retired", {16'd0, retired_cnt}, 32'hFFFF);
`endif

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
